// File: rtl/lb_reg_bank_pkg.sv
// rtl/lb_reg_bank_pkg.sv - address map and word width shared by the local-bus register bank
//
// Purpose : constants for the lb_reg_bank decoder and its testbench.
// Contents: WORD_W (data word width) and the register address constants.
//           Optional feature macro LB_TIMESTAMP_EN decides whether ADDR_TSTAMP
//           is decoded; the constant itself always exists.
package lb_regs_pkg;

   localparam int WORD_W = 32;

   localparam logic [7:0] ADDR_ID      = 8'h00;
   localparam logic [7:0] ADDR_SCRATCH = 8'h01;
   localparam logic [7:0] ADDR_PULSE   = 8'h02;
   localparam logic [7:0] ADDR_EVCNT   = 8'h03;
   localparam logic [7:0] ADDR_TRCNT   = 8'h04;
   localparam logic [7:0] ADDR_TSTAMP  = 8'h05;
   localparam logic [7:0] CTRL_BASE    = 8'h10;
   localparam logic [7:0] STAT_BASE    = 8'h20;

endpackage

// File: rtl/lb_reg_bank_if.sv
// rtl/lb_reg_bank_if.sv - local-bus signal bundle between the slow-control translator and the register bank
//
// Purpose : groups the local-bus address, data and strobes.
// Signals : lb_addr_i    8-bit register address
//           lb_wdata_i   32-bit write data
//           lb_write_n_i write strobe, active-low level
//           lb_read_i    read strobe, active-high level
//           lb_rdata_o   32-bit registered read data
// Modports: master (translator side), slave (register bank side).
// The _i/_o suffixes are named from the register bank's point of view.
interface lb_reg_bank_if;
   import lb_regs_pkg::*;

   logic [7:0]        lb_addr_i;
   logic [WORD_W-1:0] lb_wdata_i;
   logic              lb_write_n_i;
   logic              lb_read_i;
   logic [WORD_W-1:0] lb_rdata_o;

   modport master (
      output lb_addr_i,
      output lb_wdata_i,
      output lb_write_n_i,
      output lb_read_i,
      input  lb_rdata_o
   );

   modport slave (
      input  lb_addr_i,
      input  lb_wdata_i,
      input  lb_write_n_i,
      input  lb_read_i,
      output lb_rdata_o
   );

endinterface

// File: rtl/lb_reg_bank_strobe_edge.sv
// rtl/lb_reg_bank_strobe_edge.sv - turns level local-bus strobes into single-cycle commit/start pulses
//
// Purpose : module lb_strobe_edge. Registers both strobes and flags the cycle in
//           which each one becomes active.
// Ports   : clk       clock
//           reset     synchronous, active-high reset
//           write_n   write strobe level, active low
//           read      read strobe level, active high
//           wr_commit one-cycle pulse: write strobe has just gone low
//           rd_start  one-cycle pulse: read strobe has just gone high
module lb_strobe_edge (
   input  logic clk,
   input  logic reset,
   input  logic write_n,
   input  logic read,
   output logic wr_commit,
   output logic rd_start
);

   logic wr_n_q;
   logic rd_q;
   // High for the first cycle after reset releases. A write strobe that was
   // already low through reset is not a fresh edge, so it must not commit
   // even though wr_n_q comes out of reset as 1.
   logic rst_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_n_q <= 1'b1;
         rd_q   <= 1'b0;
         rst_q  <= 1'b1;
      end else begin
         wr_n_q <= write_n;
         rd_q   <= read;
         rst_q  <= 1'b0;
      end
   end

   assign wr_commit = wr_n_q & ~write_n & ~rst_q & ~reset;
   assign rd_start  = ~rd_q & read & ~reset;

endmodule

// File: rtl/lb_reg_bank.sv
// rtl/lb_reg_bank.sv - local-bus register bank: control, status, pulse and counter registers
//
// Purpose : responder on the 8-bit-address local bus. Commits one write per
//           write-strobe assertion and returns registered read data.
// Ports   : clk_100_i  system clock
//           reset_i    synchronous, active-high reset
//           lb         local bus (lb_reg_bank_if.slave)
//           ctrl_o     NUM_CTRL control registers, reg k at [32k+31:32k]
//           status_i   NUM_STAT status words, reg k at [32k+31:32k]
//           pulse_o    write data of a 0x02 commit, held for one cycle
//           event_i    event-counter increment
// Option  : LB_TIMESTAMP_EN adds a free-running cycle counter, snapshotted by
//           a read start at 0x05. Without it 0x05 is unmapped.
module lb_reg_bank
   import lb_regs_pkg::*;
#(
   parameter int          NUM_CTRL     = 4,
   parameter int          NUM_STAT     = 4,
   parameter logic [31:0] BLOCK_ID     = 32'h9000_0001,
   parameter logic [31:0] CTRL_RESET   = 32'h0000_0000,
   parameter logic [31:0] UNMAPPED_VAL = 32'h0000_0000
) (
   input  logic                       clk_100_i,
   input  logic                       reset_i,
   lb_reg_bank_if.slave               lb,
   output logic [NUM_CTRL*WORD_W-1:0] ctrl_o,
   input  logic [NUM_STAT*WORD_W-1:0] status_i,
   output logic [WORD_W-1:0]          pulse_o,
   input  logic                       event_i
);

   logic              wr_commit;
   logic              rd_start;
   logic [WORD_W-1:0] ctrl_q [NUM_CTRL];
   logic [WORD_W-1:0] stat_w [NUM_STAT];
   logic [WORD_W-1:0] scratch_q;
   logic [WORD_W-1:0] pulse_q;
   logic [WORD_W-1:0] evcnt_q;
   logic [15:0]       wr_cnt_q;
   logic [15:0]       rd_cnt_q;
   logic [WORD_W-1:0] rdata_q;
   logic [WORD_W-1:0] rd_val;
`ifdef LB_TIMESTAMP_EN
   logic [WORD_W-1:0] cycle_q;
   logic [WORD_W-1:0] tstamp_q;
`endif

   lb_strobe_edge u_strobe_edge (
      .clk       (clk_100_i),
      .reset     (reset_i),
      .write_n   (lb.lb_write_n_i),
      .read      (lb.lb_read_i),
      .wr_commit (wr_commit),
      .rd_start  (rd_start)
   );

   for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
      assign ctrl_o[g*WORD_W +: WORD_W] = ctrl_q[g];
   end

   for (genvar g = 0; g < NUM_STAT; g++) begin : g_stat_in
      assign stat_w[g] = status_i[g*WORD_W +: WORD_W];
   end

   // Read decoder works on register outputs only, so a write committed in
   // the same cycle shows up on the following read cycle.
   always_comb begin
      rd_val = UNMAPPED_VAL;
      case (lb.lb_addr_i)
         ADDR_ID:      rd_val = BLOCK_ID;
         ADDR_SCRATCH: rd_val = scratch_q;
         ADDR_PULSE:   rd_val = '0;
         ADDR_EVCNT:   rd_val = evcnt_q;
         ADDR_TRCNT:   rd_val = {wr_cnt_q, rd_cnt_q};
`ifdef LB_TIMESTAMP_EN
         ADDR_TSTAMP:  rd_val = tstamp_q;
`endif
         default:      rd_val = UNMAPPED_VAL;
      endcase
      for (int k = 0; k < NUM_CTRL; k++) begin
         if (lb.lb_addr_i == 8'(int'(CTRL_BASE) + k)) rd_val = ctrl_q[k];
      end
      for (int k = 0; k < NUM_STAT; k++) begin
         if (lb.lb_addr_i == 8'(int'(STAT_BASE) + k)) rd_val = stat_w[k];
      end
   end

   always_ff @(posedge clk_100_i) begin
      if (reset_i) begin
         for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= CTRL_RESET;
         scratch_q <= '0;
         pulse_q   <= '0;
         rdata_q   <= '0;
         evcnt_q   <= '0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
      end else begin
         if (wr_commit) begin
            if (lb.lb_addr_i == ADDR_SCRATCH) scratch_q <= lb.lb_wdata_i;
            for (int k = 0; k < NUM_CTRL; k++) begin
               if (lb.lb_addr_i == 8'(int'(CTRL_BASE) + k)) ctrl_q[k] <= lb.lb_wdata_i;
            end
         end

         pulse_q <= (wr_commit && lb.lb_addr_i == ADDR_PULSE) ? lb.lb_wdata_i : '0;

         if (lb.lb_read_i) rdata_q <= rd_val;

         // Clear-on-read reloads with this cycle's event so it is not lost;
         // the old count has already been captured into rdata_q above.
         if (rd_start && lb.lb_addr_i == ADDR_EVCNT) begin
            evcnt_q <= {{(WORD_W-1){1'b0}}, event_i};
         end else if (event_i && evcnt_q != '1) begin
            evcnt_q <= evcnt_q + 32'd1;
         end

         if (wr_commit) wr_cnt_q <= wr_cnt_q + 16'd1;
         if (rd_start)  rd_cnt_q <= rd_cnt_q + 16'd1;
      end
   end

`ifdef LB_TIMESTAMP_EN
   always_ff @(posedge clk_100_i) begin
      if (reset_i) begin
         cycle_q  <= '0;
         tstamp_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (rd_start && lb.lb_addr_i == ADDR_TSTAMP) tstamp_q <= cycle_q;
      end
   end
`endif

   assign lb.lb_rdata_o = rdata_q;
   assign pulse_o       = pulse_q;

endmodule

// File: tb/tb_lb_reg_bank.sv
// tb/tb_lb_reg_bank.sv - directed self-checking bench for lb_reg_bank
module tb_lb_reg_bank;
   import lb_regs_pkg::*;

   logic         clk_100_i = 1'b0;
   logic         reset_i   = 1'b1;
   logic [127:0] ctrl_o;
   logic [127:0] status_i;
   logic [31:0]  pulse_o;
   logic         event_i   = 1'b0;

   int checks   = 0;
   int failures = 0;

   lb_reg_bank_if lb ();

   lb_reg_bank dut (
      .clk_100_i (clk_100_i),
      .reset_i   (reset_i),
      .lb        (lb),
      .ctrl_o    (ctrl_o),
      .status_i  (status_i),
      .pulse_o   (pulse_o),
      .event_i   (event_i)
   );

   always #5 clk_100_i = ~clk_100_i;

   task automatic tick();
      @(posedge clk_100_i);
      #1;
   endtask

   task automatic do_reset();
      reset_i         = 1'b1;
      lb.lb_write_n_i = 1'b1;
      lb.lb_read_i    = 1'b0;
      lb.lb_addr_i    = 8'h00;
      lb.lb_wdata_i   = 32'h0;
      event_i         = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (lb.lb_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want %h", lb.lb_rdata_o, 32'h0); end
      checks++; if (ctrl_o !== 128'h0) begin failures++; $display("FAIL reset_ctrl: got %h want 0", ctrl_o); end
      checks++; if (pulse_o !== 32'h0) begin failures++; $display("FAIL reset_pulse: got %h want 0", pulse_o); end
      lb.lb_addr_i = ADDR_ID;
      lb.lb_read_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (lb.lb_rdata_o !== 32'h9000_0001) begin failures++; $display("FAIL id_read cycle %0d: got %h want %h", i, lb.lb_rdata_o, 32'h9000_0001); end
      end
      lb.lb_addr_i = ADDR_SCRATCH;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0) begin failures++; $display("FAIL scratch_reset: got %h want 0", lb.lb_rdata_o); end
      lb.lb_read_i = 1'b0;
      lb.lb_addr_i = ADDR_ID;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0) begin failures++; $display("FAIL rdata_hold: got %h want 0", lb.lb_rdata_o); end
   endtask

   task automatic test_ctrl_write();
      do_reset();
      lb.lb_addr_i    = 8'h12;
      lb.lb_wdata_i   = 32'hCAFE_0001;
      lb.lb_write_n_i = 1'b0;
      tick();
      checks++; if (ctrl_o[95:64] !== 32'hCAFE_0001) begin failures++; $display("FAIL ctrl2_commit: got %h want %h", ctrl_o[95:64], 32'hCAFE_0001); end
      lb.lb_wdata_i = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (ctrl_o[95:64] !== 32'hCAFE_0001) begin failures++; $display("FAIL ctrl2_no_recommit: got %h want %h", ctrl_o[95:64], 32'hCAFE_0001); end
      checks++; if (ctrl_o[31:0] !== 32'h0) begin failures++; $display("FAIL ctrl0_untouched: got %h want 0", ctrl_o[31:0]); end
      lb.lb_write_n_i = 1'b1;
      tick();
      lb.lb_addr_i = ADDR_TRCNT;
      lb.lb_read_i = 1'b1;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0001_0000) begin failures++; $display("FAIL trcnt_first: got %h want %h", lb.lb_rdata_o, 32'h0001_0000); end
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0001_0001) begin failures++; $display("FAIL trcnt_held: got %h want %h", lb.lb_rdata_o, 32'h0001_0001); end
      lb.lb_addr_i = 8'h12;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'hCAFE_0001) begin failures++; $display("FAIL ctrl2_readback: got %h want %h", lb.lb_rdata_o, 32'hCAFE_0001); end
      lb.lb_read_i = 1'b0;
      tick();
   endtask

   task automatic test_pulse();
      do_reset();
      lb.lb_addr_i    = ADDR_PULSE;
      lb.lb_wdata_i   = 32'h0000_00A5;
      lb.lb_write_n_i = 1'b0;
      tick();
      checks++; if (pulse_o !== 32'h0000_00A5) begin failures++; $display("FAIL pulse_on: got %h want %h", pulse_o, 32'hA5); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (pulse_o !== 32'h0) begin failures++; $display("FAIL pulse_off cycle %0d: got %h want 0", i, pulse_o); end
      end
      lb.lb_write_n_i = 1'b1;
      lb.lb_read_i    = 1'b1;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0) begin failures++; $display("FAIL pulse_reads_zero: got %h want 0", lb.lb_rdata_o); end
      lb.lb_read_i = 1'b0;
      tick();
   endtask

   task automatic test_event_counter();
      do_reset();
      event_i = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      lb.lb_addr_i = ADDR_EVCNT;
      lb.lb_read_i = 1'b1;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'd7) begin failures++; $display("FAIL evcnt_first: got %h want %h", lb.lb_rdata_o, 32'd7); end
      lb.lb_read_i = 1'b0;
      event_i      = 1'b0;
      tick();
      lb.lb_read_i = 1'b1;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'd1) begin failures++; $display("FAIL evcnt_second: got %h want %h", lb.lb_rdata_o, 32'd1); end
      tick();
      checks++; if (lb.lb_rdata_o !== 32'd0) begin failures++; $display("FAIL evcnt_cleared: got %h want 0", lb.lb_rdata_o); end
      lb.lb_read_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_write();
      do_reset();
      lb.lb_addr_i    = 8'h10;
      lb.lb_wdata_i   = 32'h1234_5678;
      lb.lb_write_n_i = 1'b0;
      reset_i         = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
      tick();
      tick();
      checks++; if (ctrl_o[31:0] !== 32'h0) begin failures++; $display("FAIL reset_mid_write_ctrl0: got %h want 0", ctrl_o[31:0]); end
      lb.lb_write_n_i = 1'b1;
      tick();
      lb.lb_addr_i = ADDR_TRCNT;
      lb.lb_read_i = 1'b1;
      tick();
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0000_0001) begin failures++; $display("FAIL reset_mid_write_count: got %h want %h", lb.lb_rdata_o, 32'h1); end
      lb.lb_read_i = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      lb.lb_addr_i    = ADDR_SCRATCH;
      lb.lb_wdata_i   = 32'h0000_55AA;
      lb.lb_write_n_i = 1'b0;
      lb.lb_read_i    = 1'b1;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0) begin failures++; $display("FAIL simul_prewrite: got %h want 0", lb.lb_rdata_o); end
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0000_55AA) begin failures++; $display("FAIL simul_postwrite: got %h want %h", lb.lb_rdata_o, 32'h55AA); end
      lb.lb_write_n_i = 1'b1;
      lb.lb_read_i    = 1'b0;
      tick();
      lb.lb_addr_i = ADDR_TRCNT;
      lb.lb_read_i = 1'b1;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0001_0001) begin failures++; $display("FAIL simul_trcnt: got %h want %h", lb.lb_rdata_o, 32'h0001_0001); end
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0001_0002) begin failures++; $display("FAIL simul_trcnt_held: got %h want %h", lb.lb_rdata_o, 32'h0001_0002); end
      lb.lb_read_i = 1'b0;
      tick();
   endtask

   task automatic test_unmapped();
      logic [31:0] s1;
      logic [31:0] s2;
      do_reset();
      lb.lb_read_i = 1'b1;
      lb.lb_addr_i = 8'h21;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h2222_0001) begin failures++; $display("FAIL status1: got %h want %h", lb.lb_rdata_o, 32'h2222_0001); end
      lb.lb_addr_i = 8'h7F;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0) begin failures++; $display("FAIL unmapped_7f: got %h want 0", lb.lb_rdata_o); end
      lb.lb_addr_i = 8'h21;
      tick();
      lb.lb_addr_i = 8'h24;
      tick();
      checks++; if (lb.lb_rdata_o !== 32'h0) begin failures++; $display("FAIL unmapped_24: got %h want 0", lb.lb_rdata_o); end
      lb.lb_read_i = 1'b0;
      tick();
`ifdef LB_TIMESTAMP_EN
      lb.lb_addr_i = ADDR_TSTAMP;
      lb.lb_read_i = 1'b1;
      tick();
      tick();
      s1 = lb.lb_rdata_o;
      lb.lb_read_i = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) tick();
      lb.lb_read_i = 1'b1;
      tick();
      tick();
      s2 = lb.lb_rdata_o;
      checks++; if (s2 - s1 !== 32'd13) begin failures++; $display("FAIL tstamp_delta: got %0d want 13", s2 - s1); end
`else
      lb.lb_addr_i = 8'h21;
      lb.lb_read_i = 1'b1;
      tick();
      lb.lb_addr_i = ADDR_TSTAMP;
      tick();
      s1 = lb.lb_rdata_o;
      tick();
      s2 = lb.lb_rdata_o;
      checks++; if (s1 !== 32'h0 || s2 !== 32'h0) begin failures++; $display("FAIL tstamp_unmapped: got %h/%h want 0", s1, s2); end
`endif
      lb.lb_read_i = 1'b0;
      tick();
   endtask

   initial begin
      status_i        = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
      lb.lb_addr_i    = 8'h00;
      lb.lb_wdata_i   = 32'h0;
      lb.lb_write_n_i = 1'b1;
      lb.lb_read_i    = 1'b0;
      test_reset();
      test_ctrl_write();
      test_pulse();
      test_event_counter();
      test_reset_mid_write();
      test_back_to_back();
      test_unmapped();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lb_reg_bank.md
Name: lb_reg_bank

Overview:
- Local-bus register bank: the responder on the 8-bit-address, write-only-style local bus driven by the 0x90xx slow-control translator.
- Decodes lb_addr_i and commits writes once per write-strobe assertion.
- Serves registered read data.
- Exposes control registers, status inputs, a one-shot pulse register and counters to the trigger logic.

Parameters:
NUM_CTRL, 4, number of 32-bit RW control registers (1..16)
NUM_STAT, 4, number of 32-bit RO status words (1..16)
BLOCK_ID, 32'h9000_0001, constant returned at address 0x00
CTRL_RESET, 32'h0000_0000, reset value of every control register
UNMAPPED_VAL, 32'h0000_0000, read value for unmapped addresses

Ports:
clk_100_i  in  1  system clock; the only clock
reset_i  in  1  synchronous, active-high reset
lb_addr_i  in  8  local-bus address
lb_wdata_i  in  32  local-bus write data
lb_write_n_i  in  1  write strobe, active-low level
lb_read_i  in  1  read strobe, active-high level
lb_rdata_o  out  32  registered read data
ctrl_o  out  NUM_CTRL*32  control registers, reg k at bits [32k+31:32k]
status_i  in  NUM_STAT*32  status words, synchronous to clk_100_i
pulse_o  out  32  one-cycle pulse bits
event_i  in  1  event-counter increment

Behaviour:
- Address map:
  - 0x00 ID (RO)
  - 0x01 scratch (RW)
  - 0x02 pulse (WO, reads 0)
  - 0x03 event counter (RO, clear-on-read)
  - 0x04 transaction counter (RO): [31:16] writes committed, [15:0] reads started; each half wraps
  - 0x10+k ctrl k (RW)
  - 0x20+k status k (RO)
  - Everything else returns UNMAPPED_VAL; writes to it are ignored.
  - Writes to RO addresses are ignored but still counted.
- Strobes are levels held for many cycles. Edge detection uses registers wr_n_q (reset 1) and rd_q (reset 0).
- Write commit: only in the cycle where wr_n_q=1 and lb_write_n_i=0, using lb_addr_i/lb_wdata_i of that cycle. The target register updates at the next edge. A held-low strobe never re-commits.
- Read start: the cycle where rd_q=0 and lb_read_i=1.
- lb_rdata_o:
  - Loaded every cycle lb_read_i=1 from the decoder on the current lb_addr_i (1-cycle latency).
  - Holds its value when lb_read_i=0.
  - The same-cycle commit is not visible until the next cycle, i.e. reads return the pre-write value.
- pulse_o: equals the write data for exactly one cycle after a commit to 0x02; 0 otherwise.
- Event counter:
  - 32-bit, +1 per cycle with event_i=1, saturates at 32'hFFFF_FFFF.
  - On a read start at 0x03, lb_rdata_o captures the old value and the counter loads event_i (0 or 1), so no event is lost.
  - Subsequent held-read cycles return the new value.
- Transaction counters increment on write commit and read start respectively, for any address.
- Reset (sync, highest priority):
  - ctrl_o = CTRL_RESET
  - scratch = 0
  - pulse_o = 0
  - lb_rdata_o = 0
  - both counters = 0
  - wr_n_q = 1, rd_q = 0
- A write strobe already low when reset releases does not commit. A reset mid-transaction discards it with no partial update.
- Simultaneous write commit and read start in one cycle: both are performed and both counters increment.

Optional Feature:
- LB_TIMESTAMP_EN defined:
  - Adds a free-running 32-bit cycle counter (reset 0, wraps).
  - A read start at 0x05 snapshots it into a timestamp register; reads of 0x05 return the snapshot.
- Not defined: 0x05 is unmapped and the counter logic is absent.

Decomposition:
- Package lb_regs_pkg holds the address constants ADDR_ID, ADDR_SCRATCH, ADDR_PULSE, ADDR_EVCNT, ADDR_TRCNT, ADDR_TSTAMP, CTRL_BASE and STAT_BASE, plus the 32-bit word width.
- One sub-module, lb_strobe_edge: registers both strobes and emits the wr_commit and rd_start single-cycle pulses, with the reset values above.

Test Plan:
1. Reset, then read 0x00 with read held 3 cycles -> lb_rdata_o=32'h9000_0001 from cycle 1; then read 0x01 -> 0.
2. Write 0x12 with data 32'hCAFE_0001 and write_n held low for 5 cycles -> ctrl_o reg 2 = 32'hCAFE_0001; transaction counter reads 32'h0001_0001 (including that read).
3. Write 0x02 with data 32'h0000_00A5, write_n low for 4 cycles -> pulse_o=32'hA5 for exactly one cycle, 0 afterwards.
4. Assert event_i for 7 cycles, then read 0x03 with event_i=1 in the read-start cycle -> first read returns 7; counter then 1; a second read returns 1 plus any later events.
5. Assert reset_i mid-write (write_n low, addr 0x10) and release with write_n still low -> ctrl_o reg 0 stays CTRL_RESET, no commit, write count 0.
6. Read 0x7F and 0x20+NUM_STAT -> UNMAPPED_VAL. With LB_TIMESTAMP_EN defined, two reads of 0x05 N cycles apart differ by N.
